// File: rtl/peak_bin_finder.sv
`default_nettype none
// ============================================================================
// Module   : peak_bin_finder
// Brief    : Scans FFT result RAM over a bin window and reports the bin with
//            the largest magnitude estimate (L1 or max+min/2).
// Revision : 1.0 - initial release
// ============================================================================
module peak_bin_finder #(
    parameter int DATA_W    = 10,
    parameter int ADDR_W    = 11,
    parameter int N_BINS    = 512,
    parameter int MIN_BIN   = 1,
    parameter int IMAG_BASE = 1024,
    parameter int RD_LAT    = 2,
    parameter int MAG_MODE  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] data_in,
    output logic [ADDR_W-1:0] peak_idx,
    output logic [DATA_W:0]   peak_mag,
    output logic              peak_nz
);

    localparam int                CNT_W   = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
    localparam logic [CNT_W-1:0]  c_LAT   = CNT_W'(RD_LAT);
    localparam logic [ADDR_W-1:0] c_FIRST = ADDR_W'(MIN_BIN);
    localparam logic [ADDR_W-1:0] c_LAST  = ADDR_W'(N_BINS - 1);
    localparam logic [ADDR_W-1:0] c_IMAG  = ADDR_W'(IMAG_BASE);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_ISSUE_R = 4'd1,
        S_WAIT_R  = 4'd2,
        S_ISSUE_I = 4'd3,
        S_WAIT_I  = 4'd4,
        S_MAG     = 4'd5,
        S_CMP     = 4'd6,
        S_DONE    = 4'd7
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_best_idx;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W-1:0] r_peak_idx;
    logic [DATA_W:0]   r_best_mag;
    logic [DATA_W:0]   r_mag;
    logic [DATA_W:0]   r_peak_mag;
    logic [DATA_W-1:0] r_re;
    logic [DATA_W-1:0] r_im;
    logic [CNT_W-1:0]  r_wait;
    logic              r_mem_rd;
    logic              r_peak_nz;

    logic              w_wait_last;
    logic              w_last_bin;
    logic              w_upd;
    logic [DATA_W-1:0] w_abs_r;
    logic [DATA_W-1:0] w_abs_i;
    logic [DATA_W:0]   w_mag;
    logic [DATA_W:0]   w_win_mag;
    logic [ADDR_W-1:0] w_win_idx;

    // ------------------------------------------------------------------------
    // State register and next-state logic
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_ISSUE_R;
            S_ISSUE_R: w_next = S_WAIT_R;
            S_WAIT_R:  if (w_wait_last) w_next = S_ISSUE_I;
            S_ISSUE_I: w_next = S_WAIT_I;
            S_WAIT_I:  if (w_wait_last) w_next = S_MAG;
            S_MAG:     w_next = S_CMP;
            // Compare and advance share one cycle so a bin costs 2*RD_LAT+4.
            S_CMP:     w_next = w_last_bin ? S_DONE : S_ISSUE_R;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    assign w_wait_last = (r_wait == c_LAT);
    assign w_last_bin  = (r_idx == c_LAST);
    assign w_upd       = (r_mag > r_best_mag);
    assign w_win_mag   = w_upd ? r_mag : r_best_mag;
    assign w_win_idx   = w_upd ? r_idx : r_best_idx;

    // ------------------------------------------------------------------------
    // Magnitude estimate
    // ------------------------------------------------------------------------
    // DATA_W-bit unsigned result holds 2^(DATA_W-1) for the most negative input.
    assign w_abs_r = r_re[DATA_W-1] ? (~r_re + DATA_W'(1)) : r_re;
    assign w_abs_i = r_im[DATA_W-1] ? (~r_im + DATA_W'(1)) : r_im;

    generate
        if (MAG_MODE == 1) begin : g_max_half_min
            logic [DATA_W-1:0] w_max;
            logic [DATA_W-1:0] w_min;
            logic [DATA_W-1:0] w_half;
            assign w_max  = (w_abs_r >= w_abs_i) ? w_abs_r : w_abs_i;
            assign w_min  = (w_abs_r >= w_abs_i) ? w_abs_i : w_abs_r;
            assign w_half = w_min >> 1;
            assign w_mag  = {1'b0, w_max} + {1'b0, w_half};
        end else begin : g_l1
            assign w_mag = {1'b0, w_abs_r} + {1'b0, w_abs_i};
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx      <= '0;
            r_best_idx <= '0;
            r_best_mag <= '0;
            r_mag      <= '0;
            r_re       <= '0;
            r_im       <= '0;
            r_wait     <= '0;
            r_mem_addr <= '0;
            r_mem_rd   <= 1'b0;
            r_peak_idx <= '0;
            r_peak_mag <= '0;
            r_peak_nz  <= 1'b0;
        end else begin
            r_mem_rd <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx      <= c_FIRST;
                        r_best_idx <= c_FIRST;
                        r_best_mag <= '0;
                        r_mem_addr <= c_FIRST;
                        r_mem_rd   <= 1'b1;
                    end
                end
                S_ISSUE_R, S_ISSUE_I: begin
                    r_wait <= CNT_W'(1);
                end
                S_WAIT_R: begin
                    r_wait <= r_wait + CNT_W'(1);
                    if (w_wait_last) begin
                        r_re       <= data_in;
                        r_mem_addr <= r_idx + c_IMAG;
                        r_mem_rd   <= 1'b1;
                    end
                end
                S_WAIT_I: begin
                    r_wait <= r_wait + CNT_W'(1);
                    if (w_wait_last) begin
                        r_im <= data_in;
                    end
                end
                S_MAG: begin
                    r_mag <= w_mag;
                end
                S_CMP: begin
                    r_best_mag <= w_win_mag;
                    r_best_idx <= w_win_idx;
                    // Results are loaded on entry to DONE so they are valid with the done pulse.
                    if (w_last_bin) begin
                        r_peak_idx <= w_win_idx;
                        r_peak_mag <= w_win_mag;
                        r_peak_nz  <= (w_win_mag != '0);
                    end else begin
                        r_idx      <= r_idx + ADDR_W'(1);
                        r_mem_addr <= r_idx + ADDR_W'(1);
                        r_mem_rd   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done     = (r_state == S_DONE);
    assign mem_addr = r_mem_addr;
    assign mem_rd   = r_mem_rd;
    assign peak_idx = r_peak_idx;
    assign peak_mag = r_peak_mag;
    assign peak_nz  = r_peak_nz;

endmodule
`default_nettype wire

// File: tb/tb_peak_bin_finder.sv
`default_nettype none
// ============================================================================
// Module   : tb_peak_bin_finder
// Brief    : Self-checking bench for peak_bin_finder with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_peak_bin_finder;

    localparam int L0 = 2;
    localparam int L1 = 3;
    localparam int L2 = 1;
    localparam int LAT0 = 511 * 8 + 1;
    localparam int LAT1 = 15 * 10 + 1;
    localparam int LAT2 = 1 * 6 + 1;
    localparam int SCAN_LIMIT = 6000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
    logic        busy0, busy1, busy2, done0, done1, done2, rd0, rd1, rd2, pnz0, pnz1, pnz2;
    logic [10:0] addr0, addr1, addr2, pidx0, pidx1, pidx2;
    logic [10:0] pmag0, pmag1, pmag2;
    logic [9:0]  data0, data1, data2;

    logic [9:0]  mem0 [0:2047];
    logic [9:0]  mem1 [0:2047];
    logic [9:0]  mem2 [0:2047];
    logic [9:0]  pipe0 [0:L0-1];
    logic [9:0]  pipe1 [0:L1-1];
    logic [9:0]  pipe2 [0:L2-1];

    int checks = 0;
    int errors = 0;
    int rd2_cnt = 0;
    int q_addr1 [$];

    peak_bin_finder u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
        .mem_addr(addr0), .mem_rd(rd0), .data_in(data0),
        .peak_idx(pidx0), .peak_mag(pmag0), .peak_nz(pnz0)
    );

    peak_bin_finder #(
        .DATA_W(10), .ADDR_W(11), .N_BINS(16), .MIN_BIN(1),
        .IMAG_BASE(1024), .RD_LAT(L1), .MAG_MODE(1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .mem_addr(addr1), .mem_rd(rd1), .data_in(data1),
        .peak_idx(pidx1), .peak_mag(pmag1), .peak_nz(pnz1)
    );

    peak_bin_finder #(
        .DATA_W(10), .ADDR_W(11), .N_BINS(8), .MIN_BIN(7),
        .IMAG_BASE(1024), .RD_LAT(L2), .MAG_MODE(0)
    ) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
        .mem_addr(addr2), .mem_rd(rd2), .data_in(data2),
        .peak_idx(pidx2), .peak_mag(pmag2), .peak_nz(pnz2)
    );

    // RAM models: garbage enters the pipe when no read is issued.
    always @(posedge clk) begin
        pipe0[0] <= rd0 ? mem0[addr0] : 10'($urandom);
        for (int k = 1; k < L0; k++) pipe0[k] <= pipe0[k-1];
        pipe1[0] <= rd1 ? mem1[addr1] : 10'($urandom);
        for (int k = 1; k < L1; k++) pipe1[k] <= pipe1[k-1];
        pipe2[0] <= rd2 ? mem2[addr2] : 10'($urandom);
        for (int k = 1; k < L2; k++) pipe2[k] <= pipe2[k-1];
        if (rd1) q_addr1.push_back(int'(addr1));
        if (rd2) rd2_cnt <= rd2_cnt + 1;
    end
    assign data0 = pipe0[L0-1];
    assign data1 = pipe1[L1-1];
    assign data2 = pipe2[L2-1];

    // Reference: scan the window with plain integer arithmetic.
    function automatic void model(input logic [9:0] m [0:2047], input int lo, input int hi,
                                  input int mode, output int pidx, output int pmag);
        pidx = lo;
        pmag = 0;
        for (int b = lo; b < hi; b++) begin
            int r, i, ar, ai, mag;
            r  = $signed(m[b]);
            i  = $signed(m[b + 1024]);
            ar = (r < 0) ? -r : r;
            ai = (i < 0) ? -i : i;
            if (mode == 0) mag = ar + ai;
            else           mag = ((ar > ai) ? ar : ai) + ((ar > ai) ? ai : ar) / 2;
            if (mag > pmag) begin
                pmag = mag;
                pidx = b;
            end
        end
    endfunction

    function automatic logic [9:0] rnd(input int span);
        return 10'(int'($urandom_range(2 * span)) - span);
    endfunction

    function automatic logic cur_done(input int w);
        return (w == 0) ? done0 : (w == 1) ? done1 : done2;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int which, input int span);
        for (int a = 0; a < 2048; a++) begin
            if (which == 0)      mem0[a] = (span == 0) ? 10'd0 : rnd(span);
            else if (which == 1) mem1[a] = (span == 0) ? 10'd0 : rnd(span);
            else                 mem2[a] = (span == 0) ? 10'd0 : rnd(span);
        end
    endtask

    task automatic run_scan(input int which, output int lat);
        int n;
        if (which == 0)      start0 = 1'b1;
        else if (which == 1) start1 = 1'b1;
        else                 start2 = 1'b1;
        tick();
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        n = 1;
        while (n < SCAN_LIMIT && !cur_done(which)) begin
            tick();
            n++;
        end
        lat = n;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy0); end
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done0); end
        checks++; if (rd0 !== 1'b0) begin errors++; $display("FAIL reset_mem_rd: got %b expected 0", rd0); end
        checks++; if (addr0 !== 11'd0) begin errors++; $display("FAIL reset_mem_addr: got %0d expected 0", addr0); end
        checks++; if (pidx0 !== 11'd0 || pmag0 !== 11'd0 || pnz0 !== 1'b0) begin
            errors++; $display("FAIL reset_results: got idx=%0d mag=%0d nz=%b expected 0/0/0", pidx0, pmag0, pnz0);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_peak();
        int lat;
        fill(0, 0);
        mem0[37] = 10'd100;
        mem0[37 + 1024] = 10'(-50);
        run_scan(0, lat);
        checks++; if (lat != LAT0) begin errors++; $display("FAIL peak_latency: got %0d expected %0d", lat, LAT0); end
        checks++; if (pidx0 !== 11'd37) begin errors++; $display("FAIL peak_idx: got %0d expected 37", pidx0); end
        checks++; if (pmag0 !== 11'd150) begin errors++; $display("FAIL peak_mag: got %0d expected 150", pmag0); end
        checks++; if (pnz0 !== 1'b1) begin errors++; $display("FAIL peak_nz: got %b expected 1", pnz0); end
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL busy_at_done: got %b expected 0", busy0); end
        tick();
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got %b expected 0", done0); end
    endtask

    task automatic test_most_negative();
        int lat;
        fill(0, 400);
        fill(1, 400);
        mem0[5] = 10'h200; mem0[5 + 1024] = 10'h200;
        mem1[5] = 10'h200; mem1[5 + 1024] = 10'h200;
        run_scan(0, lat);
        checks++; if (pidx0 !== 11'd5 || pmag0 !== 11'd1024) begin
            errors++; $display("FAIL most_neg_l1: got idx=%0d mag=%0d expected 5/1024", pidx0, pmag0);
        end
        tick();
        run_scan(1, lat);
        checks++; if (pidx1 !== 11'd5 || pmag1 !== 11'd768) begin
            errors++; $display("FAIL most_neg_maxmin: got idx=%0d mag=%0d expected 5/768", pidx1, pmag1);
        end
        tick();
    endtask

    task automatic test_tie();
        int lat;
        fill(0, 0);
        mem0[10] = 10'd60;
        mem0[200] = 10'd60;
        mem0[0] = 10'd511;
        run_scan(0, lat);
        checks++; if (pidx0 !== 11'd10 || pmag0 !== 11'd60 || pnz0 !== 1'b1) begin
            errors++; $display("FAIL tie_lowest_idx: got idx=%0d mag=%0d nz=%b expected 10/60/1", pidx0, pmag0, pnz0);
        end
        tick();
    endtask

    task automatic test_random();
        int lat, eidx, emag;
        for (int rep = 0; rep < 3; rep++) begin
            fill(0, (rep == 0) ? 512 : (rep == 1) ? 6 : 0);
            model(mem0, 1, 512, 0, eidx, emag);
            run_scan(0, lat);
            checks++; if (pidx0 !== 11'(eidx) || pmag0 !== 11'(emag) || pnz0 !== (emag != 0)) begin
                errors++; $display("FAIL random_l1[%0d]: got idx=%0d mag=%0d nz=%b expected %0d/%0d/%b",
                                   rep, pidx0, pmag0, pnz0, eidx, emag, emag != 0);
            end
            tick();
            fill(1, (rep == 0) ? 512 : (rep == 1) ? 5 : 0);
            model(mem1, 1, 16, 1, eidx, emag);
            run_scan(1, lat);
            checks++; if (pidx1 !== 11'(eidx) || pmag1 !== 11'(emag) || pnz1 !== (emag != 0)) begin
                errors++; $display("FAIL random_maxmin[%0d]: got idx=%0d mag=%0d nz=%b expected %0d/%0d/%b",
                                   rep, pidx1, pmag1, pnz1, eidx, emag, emag != 0);
            end
            tick();
        end
    endtask

    task automatic test_addr_seq();
        int lat, base, bad, eidx, emag;
        fill(1, 512);
        model(mem1, 1, 16, 1, eidx, emag);
        base = q_addr1.size();
        run_scan(1, lat);
        checks++; if (lat != LAT1) begin errors++; $display("FAIL addr_seq_latency: got %0d expected %0d", lat, LAT1); end
        checks++; if (q_addr1.size() - base != 30) begin
            errors++; $display("FAIL addr_seq_count: got %0d expected 30", q_addr1.size() - base);
        end else begin
            bad = -1;
            for (int k = 0; k < 30; k++) begin
                if (bad < 0 && q_addr1[base + k] != ((k % 2 == 0) ? (k / 2 + 1) : (k / 2 + 1 + 1024))) bad = k;
            end
            checks++; if (bad >= 0) begin
                errors++; $display("FAIL addr_seq_value: issue %0d got %0d expected %0d", bad, q_addr1[base + bad],
                                   (bad % 2 == 0) ? (bad / 2 + 1) : (bad / 2 + 1025));
            end
        end
        checks++; if (pidx1 !== 11'(eidx) || pmag1 !== 11'(emag)) begin
            errors++; $display("FAIL addr_seq_result: got idx=%0d mag=%0d expected %0d/%0d", pidx1, pmag1, eidx, emag);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int lat, seen_done;
        fill(0, 0);
        mem0[37] = 10'd100;
        mem0[37 + 1024] = 10'(-50);
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        seen_done = 0;
        repeat (999) begin
            tick();
            if (done0) seen_done++;
        end
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", busy0); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (busy0 !== 1'b0 || rd0 !== 1'b0) begin
            errors++; $display("FAIL mid_reset_ctrl: got busy=%b rd=%b expected 0/0", busy0, rd0);
        end
        checks++; if (pidx0 !== 11'd0 || pmag0 !== 11'd0 || pnz0 !== 1'b0) begin
            errors++; $display("FAIL mid_reset_results: got idx=%0d mag=%0d nz=%b expected 0/0/0", pidx0, pmag0, pnz0);
        end
        repeat (20) begin
            if (done0) seen_done++;
            tick();
        end
        checks++; if (seen_done != 0) begin errors++; $display("FAIL mid_reset_no_done: got %0d done pulses expected 0", seen_done); end
        run_scan(0, lat);
        checks++; if (lat != LAT0 || pidx0 !== 11'd37 || pmag0 !== 11'd150) begin
            errors++; $display("FAIL mid_reset_rescan: got lat=%0d idx=%0d mag=%0d expected %0d/37/150", lat, pidx0, pmag0, LAT0);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int n, nd, eidx, emag, last, bad_gap;
        int t [3];
        fill(1, 512);
        model(mem1, 1, 16, 1, eidx, emag);
        start1 = 1'b1;
        n = 0;
        nd = 0;
        bad_gap = 0;
        while (nd < 3 && n < 1000) begin
            tick();
            n++;
            if (done1) begin
                t[nd] = n;
                nd++;
                if (pidx1 !== 11'(eidx) || pmag1 !== 11'(emag)) bad_gap++;
            end
        end
        start1 = 1'b0;
        checks++; if (nd != 3) begin errors++; $display("FAIL b2b_count: got %0d dones expected 3", nd); end
        else begin
            checks++; if (t[0] != LAT1 || t[1] - t[0] != LAT1 + 1 || t[2] - t[1] != LAT1 + 1) begin
                errors++; $display("FAIL b2b_spacing: got %0d,%0d,%0d expected %0d,%0d,%0d",
                                   t[0], t[1] - t[0], t[2] - t[1], LAT1, LAT1 + 1, LAT1 + 1);
            end
            checks++; if (bad_gap != 0) begin errors++; $display("FAIL b2b_results: got %0d bad results expected 0", bad_gap); end
        end
        // One scan with extra start pulses while busy.
        repeat (3) tick();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        nd = 0;
        for (int c = 1; c < 2 * LAT1 + 20; c++) begin
            start1 = (c == 10 || c == 50 || c == 100) ? 1'b1 : 1'b0;
            tick();
            if (done1) nd++;
        end
        start1 = 1'b0;
        last = nd;
        checks++; if (last != 1) begin errors++; $display("FAIL busy_start_ignored: got %0d dones expected 1", last); end
        tick();
    endtask

    task automatic test_single_bin();
        int lat, base, eidx, emag;
        fill(2, 512);
        model(mem2, 7, 8, 0, eidx, emag);
        base = rd2_cnt;
        run_scan(2, lat);
        checks++; if (lat != LAT2) begin errors++; $display("FAIL single_bin_latency: got %0d expected %0d", lat, LAT2); end
        checks++; if (pidx2 !== 11'd7 || pmag2 !== 11'(emag) || pnz2 !== (emag != 0)) begin
            errors++; $display("FAIL single_bin_result: got idx=%0d mag=%0d nz=%b expected 7/%0d/%b", pidx2, pmag2, pnz2, emag, emag != 0);
        end
        checks++; if (rd2_cnt - base != 2) begin errors++; $display("FAIL single_bin_reads: got %0d expected 2", rd2_cnt - base); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single_peak();
        test_most_negative();
        test_tie();
        test_random();
        test_addr_seq();
        test_reset_mid();
        test_back_to_back();
        test_single_bin();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
